// File: rtl/umips_mmio_in.sv
// umips_mmio_in: CPU-read MMIO block for the umips core.
// Synchronises switches and pushbuttons, debounces the buttons, latches press
// events (W1C), masks them onto a level interrupt and exposes a free-running timer.
// Registers are selected by a0[6:2]; read data is returned one cycle after re.
module umips_mmio_in #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] a0,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        rd_valid,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic        irq
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [17:0]           r_sw_meta;
    logic [17:0]           r_sw_sync;
    logic [3:0]            r_key_meta;
    logic [3:0]            r_key_sync;
    logic [3:0]            r_key_lvl;
    logic [3:0][DB_W-1:0]  r_db_cnt;
    logic [3:0]            r_edge;
    logic [3:0]            r_mask;
    logic [31:0]           r_timer;
    logic [31:0]           r_rd;
    logic                  r_rd_valid;
    logic                  r_irq;

    logic [4:0]            w_idx;
    logic                  w_wr_edge;
    logic                  w_wr_mask;
    logic                  w_wr_timer;
    logic [3:0]            w_lvl_next;
    logic [3:0][DB_W-1:0]  w_cnt_next;
    logic [3:0]            w_press;
    logic [3:0]            w_edge_next;
    logic [3:0]            w_mask_next;
    logic [31:0]           w_timer_next;
    logic [31:0]           w_rd_sel;
    logic                  w_unused_addr;

    assign w_idx         = a0[6:2];
    assign w_unused_addr = ^{a0[31:7], a0[1:0]};
    assign w_wr_edge     = we && (w_idx == 5'd2);
    assign w_wr_mask     = we && (w_idx == 5'd3);
    assign w_wr_timer    = we && (w_idx == 5'd4);

    // Debounce: a key level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        w_lvl_next = r_key_lvl;
        w_cnt_next = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_key_sync[i] != r_key_lvl[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_lvl_next[i] = r_key_sync[i];
                end else begin
                    w_cnt_next[i] = r_db_cnt[i] + 1'b1;
                end
            end
        end
        // A new press is a 1->0 transition of the accepted level; it beats a same-cycle W1C clear.
        w_press      = r_key_lvl & ~w_lvl_next;
        w_edge_next  = (w_wr_edge ? (r_edge & ~wd[3:0]) : r_edge) | w_press;
        w_mask_next  = w_wr_mask ? wd[3:0] : r_mask;
        w_timer_next = w_wr_timer ? wd : (r_timer + 32'd1);
    end

    // Read mux: samples pre-write state, so re+we in one cycle returns the old value.
    always_comb begin
        w_rd_sel = '0;
        case (w_idx)
            5'd0:    w_rd_sel = {14'b0, r_sw_sync};
            5'd1:    w_rd_sel = {28'b0, r_key_lvl};
            5'd2:    w_rd_sel = {28'b0, r_edge};
            5'd3:    w_rd_sel = {28'b0, r_mask};
            5'd4:    w_rd_sel = r_timer;
            default: w_rd_sel = '0;
        endcase
    end

    // Input synchronisers, debounce state, press latches, mask and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_key_lvl  <= '1;
            r_db_cnt   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            r_key_lvl  <= w_lvl_next;
            r_db_cnt   <= w_cnt_next;
            r_edge     <= w_edge_next;
            r_mask     <= w_mask_next;
            r_irq      <= |(w_edge_next & w_mask_next);
        end
    end

    // Free-running timer and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_timer    <= w_timer_next;
            r_rd_valid <= re;
            if (re) begin
                r_rd <= w_rd_sel;
            end
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

endmodule
